resp_sched: RTL and testbench

- Round-robin scheduler that shares the 56-bit response lane feeding the 56→64 response gearbox among N response sources.
- Grants one source per message and forwards its words.
- Pads each message with zero words to a multiple of ALIGN words (ALIGN×56 bits is a whole number of 64-bit words), so every message leaves the gearbox on whole 64-bit output words.
- Enforces a maximum message length.

---
 rtl/resp_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/resp_sched.sv | 148 ++++++++++++++
 tb/tb_resp_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_pkg.sv
// Shared types and constants for the response-lane schedulers feeding the
// 56->64 response gearbox.
package resp_pkg;

   localparam int RESP_IW       = 56;
   localparam int GBOX_OW       = 64;
   // ALIGN*RESP_IW must be a multiple of GBOX_OW so messages end on whole output words.
   localparam int ALIGN_DEF     = 8;
   localparam int MAX_WORDS_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_PAD  = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_i,
// wrapping modulo N. Returns a one-hot grant and its index.
module rr_arbiter import resp_pkg::*; #(
   parameter int N  = 4,
   parameter int PW = (clog2(N) > 0) ? clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] rr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o
);

   localparam logic [PW:0] N_W = (PW + 1)'(N);

   logic [PW:0] j;
   logic        found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = '0;
      for (int off = 0; off < N; off++) begin
         // rr_i < N and off < N, so one subtraction is enough to wrap.
         j = {1'b0, rr_i} + (PW + 1)'(off);
         if (j >= N_W) j = j - N_W;
         if (!found && req_i[j[PW-1:0]]) begin
            found               = 1'b1;
            gnt_o[j[PW-1:0]]    = 1'b1;
            idx_o               = j[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/resp_sched.sv
// Round-robin scheduler sharing the response lane among N sources; pads each
// message with zero words to a multiple of ALIGN and caps message length.
module resp_sched import resp_pkg::*; #(
   parameter int N         = 4,
   parameter int IW        = RESP_IW,
   parameter int ALIGN     = ALIGN_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N-1:0]    req_last,
   input  logic [N*IW-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic [IW-1:0]   out_data,
   output logic            out_valid,
   output logic [N-1:0]    grant,
   output logic            busy,
   output logic            err_trunc
);

   localparam int PW = (clog2(N) > 0) ? clog2(N) : 1;
   localparam int CW = (clog2(ALIGN) > 0) ? clog2(ALIGN) : 1;
   localparam int LW = clog2(MAX_WORDS + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   len_q, len_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IW-1:0]   out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            err_q, err_d;

   logic [N-1:0]    arb_gnt;
   logic [PW-1:0]   arb_idx;
   logic            own_valid, own_last;
   logic [IW-1:0]   own_data;
   logic            cnt_wrap, len_hit;
   logic [CW-1:0]   cnt_inc;
   logic [LW-1:0]   len_inc;

   rr_arbiter #(.N(N), .PW(PW)) u_arb (
      .req_i (req_valid),
      .rr_i  (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign own_valid = req_valid[owner_q];
   assign own_last  = req_last[owner_q];
   assign own_data  = req_data[owner_q*IW +: IW];

   // Explicit compare keeps cnt correct when ALIGN is not a power of two.
   assign cnt_wrap = (cnt_q == CW'(ALIGN - 1));
   assign cnt_inc  = cnt_wrap ? '0 : cnt_q + 1'b1;
   assign len_inc  = len_q + 1'b1;
   assign len_hit  = (len_inc == LW'(MAX_WORDS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         rr_q        <= '0;
         owner_q     <= '0;
         grant_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         rr_q        <= rr_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      rr_d        = rr_q;
      owner_d     = owner_q;
      grant_d     = grant_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               state_d = ST_XFER;
               grant_d = arb_gnt;
               owner_d = arb_idx;
               cnt_d   = '0;
               len_d   = '0;
            end
         end
         ST_XFER: begin
            if (own_valid) begin
               out_data_d  = own_data;
               out_valid_d = 1'b1;
               cnt_d       = cnt_inc;
               len_d       = len_inc;
               if (own_last || len_hit) begin
                  rr_d  = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
                  err_d = len_hit && !own_last;
                  if (cnt_wrap) begin
                     state_d = ST_IDLE;
                     grant_d = '0;
                  end else begin
                     state_d = ST_PAD;
                  end
               end
            end
         end
         ST_PAD: begin
            out_data_d  = '0;
            out_valid_d = 1'b1;
            cnt_d       = cnt_inc;
            if (cnt_wrap) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      req_ready = (state_q == ST_XFER) ? grant_q : '0;
      busy      = (state_q != ST_IDLE);
      out_data  = out_data_q;
      out_valid = out_valid_q;
      grant     = grant_q;
      err_trunc = err_q;
   end

endmodule

// File: tb/tb_resp_sched.sv
// Self-checking bench for resp_sched: directed scenarios with random payloads
// plus a random multi-source run, all against a message-level reference model.
module tb_resp_sched;

   localparam int N = 4, IW = 56, ALIGN = 8, MAXW = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    vin = '0, lin = '0;
   logic [N*IW-1:0] din = '0;
   logic [N-1:0]    req_ready, grant;
   logic [IW-1:0]   out_data;
   logic            out_valid, busy, err_trunc;

   resp_sched #(.N(N), .IW(IW), .ALIGN(ALIGN), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .req_valid(vin), .req_last(lin), .req_data(din),
      .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
      .grant(grant), .busy(busy), .err_trunc(err_trunc)
   );

   always #5 clk = ~clk;

   int checks = 0, passed = 0;

   // Sources, traces and reference model state.
   logic [IW:0]   srcq[N][$];
   int            popped[N], gap_at[N], gap_len[N];
   int            gap_pct = 0;
   logic [IW-1:0] obs_words[$], expq[$];
   logic [N-1:0]  obs_grant[$];
   logic          obs_vld[$], obs_busy[$], obs_err[$];
   int            mm_cnt = 0;
   string         mm_note = "";
   int            m_phase, m_owner, m_len, m_pad, m_rr;
   logic          exp_vld, exp_busy, exp_err;
   logic [IW-1:0] exp_data;
   logic [N-1:0]  exp_grant;

   function automatic logic [IW-1:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[IW-1:0];
   endfunction

   function automatic void pad_expq();
      while (expq.size() % ALIGN != 0) expq.push_back('0);
   endfunction

   function automatic int stream_diff();
      int n;
      n = (obs_words.size() < expq.size()) ? obs_words.size() : expq.size();
      for (int i = 0; i < n; i++) if (obs_words[i] !== expq[i]) return i;
      return (obs_words.size() == expq.size()) ? -1 : n;
   endfunction

   function automatic void clear_all();
      for (int i = 0; i < N; i++) begin
         srcq[i].delete(); popped[i] = 0; gap_at[i] = -1; gap_len[i] = 0;
      end
      obs_words.delete(); obs_grant.delete(); obs_vld.delete();
      obs_busy.delete(); obs_err.delete(); expq.delete();
      mm_cnt = 0; mm_note = ""; gap_pct = 0;
   endfunction

   // Reference model: one message at a time, padding computed from length.
   function automatic void model_tick();
      if (rst) begin
         m_phase = 0; m_rr = 0; m_len = 0; m_pad = 0; m_owner = 0;
         exp_vld = 0; exp_data = '0; exp_grant = '0; exp_err = 0;
      end else begin
         exp_err = 0;
         if (m_phase == 0) begin
            exp_vld = 0;
            if (vin != 0) begin
               for (int k = N - 1; k >= 0; k--)
                  if (vin[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
               m_phase = 1; m_len = 0; exp_grant = '0; exp_grant[m_owner] = 1'b1;
            end
         end else if (m_phase == 1) begin
            exp_vld = vin[m_owner];
            if (vin[m_owner]) begin
               exp_data = din[m_owner*IW +: IW];
               m_len++;
               if (lin[m_owner] || m_len == MAXW) begin
                  exp_err = !lin[m_owner];
                  m_rr    = (m_owner + 1) % N;
                  m_pad   = (ALIGN - m_len % ALIGN) % ALIGN;
                  if (m_pad == 0) begin m_phase = 0; exp_grant = '0; end
                  else m_phase = 2;
               end
            end
         end else begin
            exp_vld = 1; exp_data = '0; m_pad--;
            if (m_pad == 0) begin m_phase = 0; exp_grant = '0; end
         end
      end
      exp_busy = (m_phase != 0);
   endfunction

   task automatic step();
      logic [N-1:0] acc, exp_rdy;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         vin[i] = 1'b0; lin[i] = 1'b0; din[i*IW +: IW] = rnd_word();
         if (!rst && srcq[i].size() > 0) begin
            if (gap_len[i] > 0 && popped[i] == gap_at[i]) gap_len[i]--;
            else if ($urandom_range(99) >= gap_pct) begin
               vin[i] = 1'b1; lin[i] = srcq[i][0][IW]; din[i*IW +: IW] = srcq[i][0][IW-1:0];
            end
         end
      end
      #1;
      exp_rdy = '0;
      if (m_phase == 1) exp_rdy[m_owner] = 1'b1;
      if (!rst && req_ready !== exp_rdy) begin
         mm_cnt++;
         if (mm_note == "") mm_note = $sformatf("req_ready %b vs %b", req_ready, exp_rdy);
      end
      model_tick();
      acc = vin & req_ready;
      if (!rst)
         for (int i = 0; i < N; i++)
            if (acc[i] === 1'b1) begin void'(srcq[i].pop_front()); popped[i]++; end
      @(posedge clk);
      #1;
      if (out_valid !== exp_vld || (exp_vld && out_data !== exp_data) || grant !== exp_grant ||
          busy !== exp_busy || err_trunc !== exp_err) begin
         mm_cnt++;
         if (mm_note == "")
            mm_note = $sformatf("t=%0t vld %b/%b data %h/%h grant %b/%b busy %b/%b err %b/%b", $time,
                                out_valid, exp_vld, out_data, exp_data, grant, exp_grant,
                                busy, exp_busy, err_trunc, exp_err);
      end
      obs_grant.push_back(grant); obs_vld.push_back(out_valid);
      obs_busy.push_back(busy); obs_err.push_back(err_trunc);
      if (out_valid === 1'b1) obs_words.push_back(out_data);
   endtask

   task automatic run_until_idle(input int maxc, input string name);
      int c;
      bit empty;
      c = 0;
      do begin
         step(); c++;
         empty = 1;
         for (int i = 0; i < N; i++) if (srcq[i].size() != 0) empty = 0;
      end while (!(empty && busy === 1'b0 && out_valid === 1'b0) && c < maxc);
      checks++;
      if (c >= maxc) $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, c);
      else passed++;
   endtask

   task automatic do_reset();
      rst = 1'b1; step(); step(); rst = 1'b0;
      clear_all();
   endtask

   task automatic test_reset();
      clear_all();
      rst = 1'b1; step(); step();
      checks++; if ({out_valid, busy, err_trunc} !== 3'b000)
         $display("FAIL reset_flags: vld/busy/err=%b%b%b want 000", out_valid, busy, err_trunc); else passed++;
      checks++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0000", grant); else passed++;
      checks++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else passed++;
      checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
      rst = 1'b0;
      clear_all();
   endtask

   task automatic test_align_pad();
      int d, run, best, bits, gw;
      clear_all();
      for (int k = 0; k < 3; k++) begin
         logic [IW-1:0] w; w = rnd_word();
         srcq[1].push_back({k == 2, w}); expq.push_back(w);
      end
      pad_expq();
      run_until_idle(100, "align_pad");
      checks++; if (obs_grant[0] !== 4'b0010 || obs_vld[0] !== 1'b0)
         $display("FAIL align_pad_grant: grant=%b vld=%b want 0010/0", obs_grant[0], obs_vld[0]); else passed++;
      d = stream_diff();
      checks++; if (d != -1) $display("FAIL align_pad_stream: diff at word %0d of %0d, want none", d, obs_words.size()); else passed++;
      run = 0; best = 0;
      foreach (obs_vld[i]) begin run = obs_vld[i] ? run + 1 : 0; if (run > best) best = run; end
      checks++; if (best != 8) $display("FAIL align_pad_run: consecutive valids %0d want 8", best); else passed++;
      bits = obs_words.size() * IW;
      gw = (bits % 64 == 0) ? bits / 64 : -1;
      checks++; if (gw != 7) $display("FAIL align_pad_gbox: whole 64b words %0d want 7", gw); else passed++;
      checks++; if (mm_cnt != 0) $display("FAIL align_pad_model: %0d diffs, first %s", mm_cnt, mm_note); else passed++;
   endtask

   task automatic test_two_sources();
      int d, g2;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         logic [IW-1:0] w; w = rnd_word(); srcq[0].push_back({k == 1, w}); expq.push_back(w);
      end
      pad_expq();
      for (int k = 0; k < 2; k++) begin
         logic [IW-1:0] w; w = rnd_word(); srcq[2].push_back({k == 1, w}); expq.push_back(w);
      end
      pad_expq();
      run_until_idle(100, "two_src");
      checks++; if (obs_grant[0] !== 4'b0001) $display("FAIL two_src_first: grant %b want 0001", obs_grant[0]); else passed++;
      g2 = -1;
      foreach (obs_grant[i]) if (g2 < 0 && obs_grant[i] === 4'b0100) g2 = i;
      checks++;
      if (g2 < 1 || g2 + 1 >= obs_vld.size())
         $display("FAIL two_src_second: grant 0100 at cycle %0d, want it after source 0", g2);
      else if ({obs_grant[g2-1], obs_vld[g2-1], obs_vld[g2], obs_vld[g2+1]} !== 7'b0000_101)
         $display("FAIL two_src_gap: grant/vld around handover %b %b%b%b want 0000 101",
                  obs_grant[g2-1], obs_vld[g2-1], obs_vld[g2], obs_vld[g2+1]);
      else passed++;
      d = stream_diff();
      checks++; if (d != -1) $display("FAIL two_src_stream: diff at word %0d, want none", d); else passed++;
      checks++; if (mm_cnt != 0) $display("FAIL two_src_model: %0d diffs, first %s", mm_cnt, mm_note); else passed++;
   endtask

   task automatic test_exact_align();
      int d, nv, i8;
      clear_all();
      for (int k = 0; k < 8; k++) begin
         logic [IW-1:0] w; w = rnd_word(); srcq[3].push_back({k == 7, w}); expq.push_back(w);
      end
      run_until_idle(100, "exact");
      checks++; if (obs_grant[0] !== 4'b1000) $display("FAIL exact_grant: grant %b want 1000", obs_grant[0]); else passed++;
      d = stream_diff();
      checks++; if (d != -1) $display("FAIL exact_stream: diff at word %0d of %0d, want 8 words no pad", d, obs_words.size()); else passed++;
      nv = 0; i8 = -1;
      foreach (obs_vld[i]) if (obs_vld[i]) begin nv++; if (nv == 8) i8 = i; end
      checks++;
      if (i8 < 0) $display("FAIL exact_idle: eighth word never seen, want it");
      else if ({obs_busy[i8], obs_grant[i8]} !== 5'b0) $display("FAIL exact_idle: busy=%b grant=%b with word 8, want 0/0000", obs_busy[i8], obs_grant[i8]);
      else passed++;
      checks++; if (mm_cnt != 0) $display("FAIL exact_model: %0d diffs, first %s", mm_cnt, mm_note); else passed++;
   endtask

   task automatic test_trunc();
      logic [IW-1:0] a[70];
      logic [IW-1:0] b;
      logic [N-1:0]  gseq[$];
      int d, nerr, wi, nv;
      do_reset();
      for (int k = 0; k < 70; k++) begin a[k] = rnd_word(); srcq[0].push_back({k == 69, a[k]}); end
      b = rnd_word(); srcq[1].push_back({1'b1, b});
      for (int k = 0; k < 64; k++) expq.push_back(a[k]);
      expq.push_back(b); pad_expq();
      for (int k = 64; k < 70; k++) expq.push_back(a[k]);
      pad_expq();
      run_until_idle(400, "trunc");
      d = stream_diff();
      checks++; if (d != -1) $display("FAIL trunc_stream: diff at word %0d, want none", d); else passed++;
      nerr = 0; wi = -1; nv = 0;
      foreach (obs_vld[i]) begin
         if (obs_vld[i]) nv++;
         if (obs_err[i]) begin nerr++; wi = nv; end
      end
      checks++; if (nerr != 1) $display("FAIL trunc_err_count: %0d pulses want 1", nerr); else passed++;
      checks++; if (wi != 64) $display("FAIL trunc_err_word: pulse with word %0d want 64", wi); else passed++;
      foreach (obs_grant[i]) if (obs_grant[i] != 0 && (i == 0 || obs_grant[i-1] !== obs_grant[i])) gseq.push_back(obs_grant[i]);
      checks++;
      if (gseq.size() != 3 || {gseq[0], gseq[1], gseq[2]} !== 12'b0001_0010_0001)
         $display("FAIL trunc_order: %0d grants, want 0001 0010 0001", gseq.size());
      else passed++;
      checks++; if (mm_cnt != 0) $display("FAIL trunc_model: %0d diffs, first %s", mm_cnt, mm_note); else passed++;
   endtask

   task automatic test_bubble();
      int d, nb, ng;
      clear_all();
      for (int k = 0; k < 5; k++) begin
         logic [IW-1:0] w; w = rnd_word(); srcq[2].push_back({k == 4, w}); expq.push_back(w);
      end
      pad_expq();
      gap_at[2] = 2; gap_len[2] = 3;
      run_until_idle(100, "bubble");
      d = stream_diff();
      checks++; if (d != -1) $display("FAIL bubble_stream: diff at word %0d, want none", d); else passed++;
      nb = 0; ng = 0;
      foreach (obs_grant[i]) if (obs_grant[i] === 4'b0100) begin ng++; if (!obs_vld[i]) nb++; end
      checks++; if (nb != 4) $display("FAIL bubble_gaps: %0d non-valid granted cycles want 4", nb); else passed++;
      checks++; if (ng != 11) $display("FAIL bubble_hold: grant held %0d cycles want 11", ng); else passed++;
      checks++; if (mm_cnt != 0) $display("FAIL bubble_model: %0d diffs, first %s", mm_cnt, mm_note); else passed++;
   endtask

   task automatic test_rst_pad();
      int d;
      clear_all();
      srcq[1].push_back({1'b1, rnd_word()});
      repeat (4) step();
      checks++; if ({busy, out_valid, out_data} !== {2'b11, {IW{1'b0}}})
         $display("FAIL rstpad_inpad: busy/vld=%b%b data=%h want 11/0", busy, out_valid, out_data); else passed++;
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if ({out_valid, busy, grant} !== 6'b0) $display("FAIL rstpad_clear: vld=%b busy=%b grant=%b want 0/0/0000", out_valid, busy, grant); else passed++;
      clear_all();
      for (int k = 0; k < 3; k++) begin
         logic [IW-1:0] w; w = rnd_word(); srcq[2].push_back({k == 2, w}); expq.push_back(w);
      end
      pad_expq();
      run_until_idle(100, "rstpad");
      checks++; if (obs_grant[0] !== 4'b0100) $display("FAIL rstpad_grant: grant %b want 0100", obs_grant[0]); else passed++;
      d = stream_diff();
      checks++; if (d != -1) $display("FAIL rstpad_stream: diff at word %0d, want 3 words + 5 pad", d); else passed++;
   endtask

   task automatic test_random();
      int total;
      do_reset();
      total = 0;
      gap_pct = 25;
      for (int s = 0; s < N; s++)
         for (int m = 0; m < int'($urandom_range(3, 1)); m++) begin
            int len;
            len = $urandom_range(20, 1);
            total += ((len + ALIGN - 1) / ALIGN) * ALIGN;
            for (int k = 0; k < len; k++) srcq[s].push_back({k == len - 1, rnd_word()});
         end
      run_until_idle(3000, "random");
      checks++; if (obs_words.size() != total) $display("FAIL random_count: %0d words want %0d", obs_words.size(), total); else passed++;
      checks++; if (mm_cnt != 0) $display("FAIL random_model: %0d diffs, first %s", mm_cnt, mm_note); else passed++;
   endtask

   initial begin
      test_reset();
      test_align_pad();
      test_two_sources();
      test_exact_align();
      test_trunc();
      test_bubble();
      test_rst_pad();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
